// File: rtl/dtu_word_unpacker.sv
// LiTe-DTU lane-0 word unpacker: classifies aligned words and streams their samples one per cycle.
// Optional macro DTU_UNPACK_STATS_EN builds the frame/error/last-frame-sample counters.
module dtu_word_unpacker #(
  parameter int CNT_W = 16
) (
  input  logic             clk_160,
  input  logic             rst,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             calibration_busy,
  output logic [11:0]      sample_data,
  output logic             sample_gain,
  output logic             sample_is_bl,
  output logic             sample_is_hdr,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [2:0]       word_type,
  output logic             dtu_reset_seen,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] ser_error_count,
  output logic [CNT_W-1:0] last_frame_samples
);

  typedef enum logic {S_EMPTY, S_EMIT} state_e;

  localparam logic [2:0] T_ERR  = 3'd0;
  localparam logic [2:0] T_BL5  = 3'd1;
  localparam logic [2:0] T_BLN  = 3'd2;
  localparam logic [2:0] T_SIG2 = 3'd3;
  localparam logic [2:0] T_SIG1 = 3'd4;
  localparam logic [2:0] T_HDR  = 3'd5;
  localparam logic [2:0] T_IDLE = 3'd6;
  localparam logic [2:0] T_TRL  = 3'd7;

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [2:0] t;
    t = T_ERR;
    if (w[31:30] == 2'b01)          t = T_BL5;
    else if (w[31:30] == 2'b10)     t = (w[26:24] >= 3'd1 && w[26:24] <= 3'd4) ? T_BLN : T_ERR;
    else if (w[31:26] == 6'b001010) t = T_SIG2;
    else if (w[31:25] == 7'b0010110) t = T_SIG1;
    else if (w[31:25] == 7'b0010111) t = T_HDR;
    else if (w[31:28] == 4'b1110)   t = T_IDLE;
    else if (w[31:26] == 6'b001101) t = T_IDLE;
    else if (w[31:28] == 4'b1101)   t = T_TRL;
    return t;
  endfunction

  function automatic logic [2:0] n_samples(input logic [2:0] t, input logic [31:0] w);
    logic [2:0] n;
    n = 3'd0;
    case (t)
      T_BL5:          n = 3'd5;
      T_BLN:          n = w[26:24];
      T_SIG2:         n = 3'd2;
      T_SIG1, T_HDR:  n = 3'd1;
      default:        n = 3'd0;
    endcase
    return n;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic [2:0]  idx_q, idx_d;
  logic [29:0] word_q;
  logic [2:0]  cls_q;
  logic [2:0]  word_type_q;
  logic        rst_seen_q;

  logic [2:0]  cls_in;
  logic [2:0]  n_in;
  logic        accept, decode, load, take;

  assign cls_in     = classify(word_in);
  assign n_in       = n_samples(cls_in, word_in);
  assign word_ready = (state_q == S_EMPTY) || (rem_q == 3'd1 && sample_ready);
  assign accept     = word_valid && word_ready;
  // Words accepted during calibration are swallowed without touching any status.
  assign decode     = accept && !calibration_busy;
  assign load       = decode && (n_in != 3'd0);
  assign sample_valid = (state_q == S_EMIT);
  assign take       = sample_valid && sample_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    if (take) begin
      if (rem_q == 3'd1) begin
        state_d = S_EMPTY;
      end else begin
        rem_d = rem_q - 3'd1;
        idx_d = idx_q + 3'd1;
      end
    end
    if (load) begin
      state_d = S_EMIT;
      rem_d   = n_in;
      idx_d   = 3'd0;
    end
  end

  always_ff @(posedge clk_160) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      rem_q       <= 3'd0;
      idx_q       <= 3'd0;
      word_type_q <= T_ERR;
      rst_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      rst_seen_q <= decode && (word_in[31:26] == 6'b001101);
      if (decode) word_type_q <= cls_in;
    end
  end

  always_ff @(posedge clk_160) begin
    if (load) begin
      word_q <= word_in[29:0];
      cls_q  <= cls_in;
    end
  end

  // Sample fields are muxed from the held word; outputs read zero when no sample is offered.
  always_comb begin
    sample_data   = 12'd0;
    sample_gain   = 1'b0;
    sample_is_bl  = 1'b0;
    sample_is_hdr = 1'b0;
    if (state_q == S_EMIT) begin
      case (cls_q)
        T_BL5, T_BLN: begin
          sample_is_bl = 1'b1;
          case (idx_q)
            3'd0:    sample_data = {6'd0, word_q[5:0]};
            3'd1:    sample_data = {6'd0, word_q[11:6]};
            3'd2:    sample_data = {6'd0, word_q[17:12]};
            3'd3:    sample_data = {6'd0, word_q[23:18]};
            default: sample_data = {6'd0, word_q[29:24]};
          endcase
        end
        T_SIG2: begin
          if (idx_q == 3'd0) {sample_gain, sample_data} = word_q[12:0];
          else               {sample_gain, sample_data} = word_q[25:13];
        end
        T_HDR: begin
          {sample_gain, sample_data} = word_q[12:0];
          sample_is_hdr = 1'b1;
        end
        default: {sample_gain, sample_data} = word_q[12:0];
      endcase
    end
  end

  assign word_type      = word_type_q;
  assign dtu_reset_seen = rst_seen_q;

`ifdef DTU_UNPACK_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] run_q, frame_q, err_q, last_q;

  always_ff @(posedge clk_160) begin
    if (rst) begin
      run_q   <= '0;
      frame_q <= '0;
      err_q   <= '0;
      last_q  <= '0;
    end else begin
      // A sample taken on the same edge as a trailer belongs to the frame that trailer closes.
      if (decode && cls_in == T_TRL) begin
        frame_q <= sat_inc(frame_q);
        last_q  <= take ? sat_inc(run_q) : run_q;
        run_q   <= '0;
      end else if (take) begin
        run_q <= sat_inc(run_q);
      end
      if (decode && cls_in == T_ERR) err_q <= sat_inc(err_q);
    end
  end

  assign frame_count        = frame_q;
  assign ser_error_count    = err_q;
  assign last_frame_samples = last_q;
`else
  assign frame_count        = '0;
  assign ser_error_count    = '0;
  assign last_frame_samples = '0;
`endif

endmodule

// File: tb/tb_dtu_word_unpacker.sv
// Directed bench for dtu_word_unpacker; counter expectations follow DTU_UNPACK_STATS_EN.
module tb_dtu_word_unpacker;
  localparam int CNT_W = 16;
`ifdef DTU_UNPACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk_160 = 1'b0;
  logic             rst;
  logic [31:0]      word_in;
  logic             word_valid;
  logic             word_ready;
  logic             calibration_busy;
  logic [11:0]      sample_data;
  logic             sample_gain;
  logic             sample_is_bl;
  logic             sample_is_hdr;
  logic             sample_valid;
  logic             sample_ready;
  logic [2:0]       word_type;
  logic             dtu_reset_seen;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] ser_error_count;
  logic [CNT_W-1:0] last_frame_samples;

  int tests = 0;
  int fails = 0;

  dtu_word_unpacker #(.CNT_W(CNT_W)) dut (
    .clk_160(clk_160), .rst(rst),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .calibration_busy(calibration_busy),
    .sample_data(sample_data), .sample_gain(sample_gain),
    .sample_is_bl(sample_is_bl), .sample_is_hdr(sample_is_hdr),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .word_type(word_type), .dtu_reset_seen(dtu_reset_seen),
    .frame_count(frame_count), .ser_error_count(ser_error_count),
    .last_frame_samples(last_frame_samples)
  );

  always #5 clk_160 = ~clk_160;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk_160);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
  endtask

  task automatic expect_sample(input string tag, input logic [11:0] d, input logic g,
                               input logic bl, input logic hdr);
    @(negedge clk_160);
    chk({tag, "_valid"}, sample_valid, 1'b1);
    chk({tag, "_data"}, sample_data, d);
    chk({tag, "_flags"}, {sample_gain, sample_is_bl, sample_is_hdr}, {g, bl, hdr});
    step();
  endtask

  task automatic check_counters(input string tag, input int fc, input int ec, input int lf);
    chk({tag, "_frames"}, frame_count, st(fc));
    chk({tag, "_errors"}, ser_error_count, st(ec));
    chk({tag, "_lastfs"}, last_frame_samples, st(lf));
  endtask

  initial begin
    rst = 1'b1; word_in = '0; word_valid = 1'b0;
    calibration_busy = 1'b0; sample_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk_160);
    chk("rst_svalid", sample_valid, 1'b0);
    chk("rst_sdata", sample_data, 12'd0);
    chk("rst_flags", {sample_gain, sample_is_bl, sample_is_hdr}, 3'b000);
    chk("rst_wready", word_ready, 1'b1);
    chk("rst_wtype", word_type, 3'd0);
    chk("rst_rseen", dtu_reset_seen, 1'b0);
    check_counters("rst", 0, 0, 0);
    step();

    // BL5 with fields 1..5
    send(32'h4510_3081);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_160);
      chk("bl5_valid", sample_valid, 1'b1);
      chk("bl5_data", sample_data, 12'(i));
      chk("bl5_flags", {sample_gain, sample_is_bl, sample_is_hdr}, 3'b010);
      chk("bl5_wready", word_ready, (i == 5) ? 1'b1 : 1'b0);
      chk("bl5_wtype", word_type, 3'd1);
      step();
    end
    @(negedge clk_160);
    chk("bl5_done", sample_valid, 1'b0);
    step();

    // SIG2 with backpressure
    sample_ready = 1'b0;
    send(32'h2B57_8123);
    @(negedge clk_160);
    chk("sig2_a_stall", {sample_valid, sample_gain, sample_data}, {1'b1, 1'b0, 12'h123});
    chk("sig2_wready_stall", word_ready, 1'b0);
    step(); sample_ready = 1'b1;
    @(negedge clk_160);
    chk("sig2_a_held", {sample_valid, sample_gain, sample_data}, {1'b1, 1'b0, 12'h123});
    step(); sample_ready = 1'b0;
    @(negedge clk_160);
    chk("sig2_b_stall", {sample_valid, sample_gain, sample_data}, {1'b1, 1'b1, 12'hABC});
    chk("sig2_wtype", word_type, 3'd3);
    step(); sample_ready = 1'b1;
    @(negedge clk_160);
    chk("sig2_b_held", {sample_valid, sample_gain, sample_data}, {1'b1, 1'b1, 12'hABC});
    step();
    @(negedge clk_160);
    chk("sig2_done", sample_valid, 1'b0);
    step();

    // BLN n=3 then n=6 (error)
    send(32'h8300_9207);
    expect_sample("bln0", 12'h007, 1'b0, 1'b1, 1'b0);
    expect_sample("bln1", 12'h008, 1'b0, 1'b1, 1'b0);
    expect_sample("bln2", 12'h009, 1'b0, 1'b1, 1'b0);
    @(negedge clk_160);
    chk("bln_done", sample_valid, 1'b0);
    chk("bln_wtype", word_type, 3'd2);
    step();
    send(32'h8600_0000);
    @(negedge clk_160);
    chk("err_svalid", sample_valid, 1'b0);
    chk("err_wtype", word_type, 3'd0);
    check_counters("err", 0, 1, 0);
    step();

    // Frames: back-to-back HDR, SIG1, SIG1, TRAILER at one word per cycle
    rst = 1'b1; step(); rst = 1'b0;
    word_in = 32'h2E00_15A5; word_valid = 1'b1;
    step();
    word_in = 32'h2C00_0321;
    @(negedge clk_160);
    chk("hdr_sample", {sample_valid, sample_is_hdr, sample_gain, sample_data}, {3'b111, 12'h5A5});
    chk("hdr_wready", word_ready, 1'b1);
    step();
    word_in = 32'h2C00_1777;
    @(negedge clk_160);
    chk("sig1a_sample", {sample_valid, sample_is_hdr, sample_gain, sample_data}, {3'b100, 12'h321});
    chk("sig1a_wtype", word_type, 3'd4);
    step();
    word_in = 32'hD000_0000;
    @(negedge clk_160);
    chk("sig1b_sample", {sample_valid, sample_is_hdr, sample_gain, sample_data}, {3'b101, 12'h777});
    chk("sig1b_wready", word_ready, 1'b1);
    step();
    word_valid = 1'b0;
    @(negedge clk_160);
    chk("trl1_svalid", sample_valid, 1'b0);
    chk("trl1_wtype", word_type, 3'd7);
    check_counters("trl1", 1, 0, 3);
    step();
    send(32'h2E00_15A5);
    expect_sample("hdr2", 12'h5A5, 1'b1, 1'b0, 1'b1);
    send(32'hD000_0000);
    @(negedge clk_160);
    check_counters("trl2", 2, 0, 1);
    step();

    // IDLE then RESET
    send(32'hE000_0000);
    @(negedge clk_160);
    chk("idle_svalid", sample_valid, 1'b0);
    chk("idle_wtype", word_type, 3'd6);
    chk("idle_rseen", dtu_reset_seen, 1'b0);
    step();
    send(32'h3400_0000);
    @(negedge clk_160);
    chk("reset_pulse", dtu_reset_seen, 1'b1);
    chk("reset_svalid", sample_valid, 1'b0);
    step();
    @(negedge clk_160);
    chk("reset_pulse_end", dtu_reset_seen, 1'b0);
    step();

    // Calibration discards words and leaves status untouched
    send(32'h3400_0000);
    step();
    calibration_busy = 1'b1;
    send(32'h0C00_0000);   // would be an error word
    @(negedge clk_160);
    chk("cal_err_ignored", ser_error_count, st(0));
    step();
    send(32'h2B57_8123);
    @(negedge clk_160);
    chk("cal_svalid", sample_valid, 1'b0);
    chk("cal_wtype", word_type, 3'd6);
    chk("cal_rseen", dtu_reset_seen, 1'b0);
    step();
    send(32'hD000_0000);
    @(negedge clk_160);
    check_counters("cal", 2, 0, 1);
    chk("cal_svalid2", sample_valid, 1'b0);
    step();
    calibration_busy = 1'b0;

    // Reset in the middle of a BL5 drain
    send(32'h4510_3081);
    expect_sample("bl5r0", 12'h001, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk_160);
    chk("midrst_svalid", sample_valid, 1'b0);
    chk("midrst_sdata", sample_data, 12'd0);
    chk("midrst_wready", word_ready, 1'b1);
    chk("midrst_wtype", word_type, 3'd0);
    check_counters("midrst", 0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
